streaming_write_master: RTL and testbench
=========================================

// Module: streaming_write_master
// PURPOSE
//  Avalon-MM write master, the write-side counterpart of the DMA read path.
//  User logic pushes words into an internal show-ahead FIFO. A control port
//  supplies base, length and go; the master drains the FIFO as single-word
//  writes, honouring waitrequest, and asserts done once all bytes are posted.
// PARAMETERS
//  DATAWIDTH            32  data bus width in bits
//  BYTEENABLEWIDTH      4   bytes per word; address step per write
//  BYTEENABLEWIDTH_LOG2 2   log2(BYTEENABLEWIDTH)
//  ADDRESSWIDTH         32  byte address and length width
//  FIFODEPTH            32  user FIFO depth in words (power of 2)
//  FIFODEPTH_LOG2       5   log2(FIFODEPTH)
// PORTS
//  clk                         in  1                   clock
//  reset                       in  1                   async, active-high reset
//  coe_control_fixed_location  in  1                   1 = write all words to base
//  coe_control_write_base      in  ADDRESSWIDTH        byte address, word-aligned
//  coe_control_write_length    in  ADDRESSWIDTH        transfer length in bytes
//  coe_control_go              in  1                   1-cycle pulse: load and start
//  coe_control_done            out 1                   all words posted (length==0)
//  coe_user_write_buffer       in  1                   push user data into FIFO
//  coe_user_buffer_data        in  DATAWIDTH           word to push
//  coe_user_buffer_full        out 1                   FIFO full; pushes dropped
//  coe_user_buffer_used        out FIFODEPTH_LOG2+1    words held in FIFO (0..DEPTH)
//  master_address              out ADDRESSWIDTH        byte address
//  master_write                out 1                   write request
//  master_byteenable           out BYTEENABLEWIDTH     all ones
//  master_writedata            out DATAWIDTH           FIFO head word
//  master_waitrequest          in  1                   slave stall
// BEHAVIOUR
//  Reset: address=0, length=0, fixed_d1=0, FIFO empty, used=0, full=0,
//   master_write=0, done=1. Reset may assert mid-transfer: the transfer is
//   abandoned and all FIFO contents are lost.
//  go: loads address<=base, fixed_d1<=fixed_location, and
//   length<=length_in & ~(BYTEENABLEWIDTH-1), truncating the low bits.
//   go reloads unconditionally, even mid-transfer. FIFO contents are kept.
//  master_write = (length!=0) & !fifo_empty. This is combinational from registers.
//  master_writedata = FIFO head (show-ahead). master_byteenable = all ones.
//  accept = master_write & !master_waitrequest. On accept:
//   - pop the FIFO;
//   - length -= BYTEENABLEWIDTH;
//   - address += BYTEENABLEWIDTH unless fixed_d1 (address wraps mod 2^ADDRESSWIDTH).
//  If go and accept fall in the same cycle, go wins for address and length;
//   the FIFO pop still occurs.
//  While waitrequest=1, address, writedata and write stay stable; nothing pops.
//  length never underflows; it is decremented only while nonzero.
//  done = (length==0). It rises the cycle after the final accept.
//   Writes are posted; there is no response tracking.
//  FIFO starvation (empty, length!=0): write=0 and the transfer pauses;
//   it resumes the cycle after the next push (1-cycle show-ahead latency).
//  Push when full: the data is dropped and the FIFO is unchanged, even if a
//   pop occurs in the same cycle. Push+pop when not full: used is unchanged.
//  Push while length==0 is legal; data waits for the next go.
//  full = (used==FIFODEPTH). used is registered and updates the cycle after
//   a push/pop.
// STRUCTURE
//  Sub-module write_master_fifo (params WIDTH, DEPTH, DEPTH_LOG2):
//   - show-ahead, registered storage, async reset;
//   - ports: push, din, pop, dout, empty, full, used;
//   - wr/rd pointers DEPTH_LOG2 wide wrap naturally; used is DEPTH_LOG2+1 bits.
//  Top level holds the address/length/fixed_d1 registers and the accept logic.
//  No shared package: all constants are derived from parameters.
// TESTING
//  1 Reset: assert reset -> done=1, write=0, full=0, used=0, address=0.
//  2 base=0x1000, len=16, push A0..A3, wait=0 -> writes at 0x1000/04/08/0C
//    with A0..A3 in order; done=1 the cycle after the 4th accept.
//  3 Hold waitrequest=1 for 3 cycles on the 2nd write -> address=0x1004 and
//    data=A1 stable; used unchanged; length stays 12 until accepted.
//  4 fixed_location=1, base=0x2000, len=12 -> 3 writes, all to 0x2000;
//    len=14 -> truncated to 12 -> 3 writes.
//  5 len=0, push 33 words -> full=1, used=32, word 33 dropped;
//    then go len=128 -> 32 writes of words 1..32, done=1, used=0.
//  6 len=8, push 1 word -> one write, then write=0 (starved, done=0);
//    push 2nd 5 cycles later -> write resumes next cycle, then done=1.

Source files
------------

// File: rtl/write_master_fifo.sv
// Show-ahead FIFO feeding the streaming write master; the head word is visible on dout
// whenever the FIFO is not empty.
module write_master_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   used
);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   used_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign empty     = (used_r == (DEPTH_LOG2+1)'(0));
  assign full      = (used_r == (DEPTH_LOG2+1)'(DEPTH));
  assign used      = used_r;
  assign dout      = mem_r[rd_ptr_r];
  // A push into a full FIFO is dropped even when a pop frees a slot that same cycle.
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array; contents need no reset because used_r gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= DEPTH_LOG2'(0);
      rd_ptr_r <= DEPTH_LOG2'(0);
      used_r   <= (DEPTH_LOG2+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   used_r <= used_r + (DEPTH_LOG2+1)'(1);
        2'b01:   used_r <= used_r - (DEPTH_LOG2+1)'(1);
        default: used_r <= used_r;
      endcase
    end
  end

endmodule

// File: rtl/streaming_write_master.sv
// Avalon-MM write master: drains a user-filled FIFO as single-word posted writes
// starting at a programmed base address for a programmed byte length.
module streaming_write_master #(
  parameter int DATAWIDTH            = 32,
  parameter int BYTEENABLEWIDTH      = 4,
  parameter int BYTEENABLEWIDTH_LOG2 = 2,
  parameter int ADDRESSWIDTH         = 32,
  parameter int FIFODEPTH            = 32,
  parameter int FIFODEPTH_LOG2       = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        coe_control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]     coe_control_write_base,
  input  logic [ADDRESSWIDTH-1:0]     coe_control_write_length,
  input  logic                        coe_control_go,
  output logic                        coe_control_done,
  input  logic                        coe_user_write_buffer,
  input  logic [DATAWIDTH-1:0]        coe_user_buffer_data,
  output logic                        coe_user_buffer_full,
  output logic [FIFODEPTH_LOG2:0]     coe_user_buffer_used,
  output logic [ADDRESSWIDTH-1:0]     master_address,
  output logic                        master_write,
  output logic [BYTEENABLEWIDTH-1:0]  master_byteenable,
  output logic [DATAWIDTH-1:0]        master_writedata,
  input  logic                        master_waitrequest
);

  localparam logic [ADDRESSWIDTH-1:0] STEP     = ADDRESSWIDTH'(1 << BYTEENABLEWIDTH_LOG2);
  localparam logic [ADDRESSWIDTH-1:0] LOW_MASK = STEP - ADDRESSWIDTH'(1);

  logic [ADDRESSWIDTH-1:0] address_r;
  logic [ADDRESSWIDTH-1:0] length_r;
  logic                    fixed_d1_r;
  logic                    fifo_empty_s;
  logic                    accept_s;

  write_master_fifo #(
    .WIDTH      (DATAWIDTH),
    .DEPTH      (FIFODEPTH),
    .DEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (coe_user_write_buffer),
    .din   (coe_user_buffer_data),
    .pop   (accept_s),
    .dout  (master_writedata),
    .empty (fifo_empty_s),
    .full  (coe_user_buffer_full),
    .used  (coe_user_buffer_used)
  );

  assign master_write      = (length_r != ADDRESSWIDTH'(0)) & ~fifo_empty_s;
  assign accept_s          = master_write & ~master_waitrequest;
  assign master_address    = address_r;
  assign master_byteenable = {BYTEENABLEWIDTH{1'b1}};
  assign coe_control_done  = (length_r == ADDRESSWIDTH'(0));

  // Transfer state: go reloads unconditionally and overrides a coincident accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_r  <= ADDRESSWIDTH'(0);
      length_r   <= ADDRESSWIDTH'(0);
      fixed_d1_r <= 1'b0;
    end else if (coe_control_go) begin
      address_r  <= coe_control_write_base;
      length_r   <= coe_control_write_length & ~LOW_MASK;
      fixed_d1_r <= coe_control_fixed_location;
    end else if (accept_s) begin
      // accept implies length_r is nonzero, so this never underflows
      length_r <= length_r - STEP;
      if (!fixed_d1_r) begin
        address_r <= address_r + STEP;
      end
    end
  end

endmodule

// File: tb/tb_streaming_write_master.sv
// Randomized self-checking bench for streaming_write_master against a queue-based
// model of the user FIFO and the programmed transfer.
module tb_streaming_write_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        coe_control_fixed_location;
  logic [31:0] coe_control_write_base;
  logic [31:0] coe_control_write_length;
  logic        coe_control_go;
  logic        coe_control_done;
  logic        coe_user_write_buffer;
  logic [31:0] coe_user_buffer_data;
  logic        coe_user_buffer_full;
  logic [5:0]  coe_user_buffer_used;
  logic [31:0] master_address;
  logic        master_write;
  logic [3:0]  master_byteenable;
  logic [31:0] master_writedata;
  logic        master_waitrequest;

  streaming_write_master dut (
    .clk                        (clk),
    .reset                      (reset),
    .coe_control_fixed_location (coe_control_fixed_location),
    .coe_control_write_base     (coe_control_write_base),
    .coe_control_write_length   (coe_control_write_length),
    .coe_control_go             (coe_control_go),
    .coe_control_done           (coe_control_done),
    .coe_user_write_buffer      (coe_user_write_buffer),
    .coe_user_buffer_data       (coe_user_buffer_data),
    .coe_user_buffer_full       (coe_user_buffer_full),
    .coe_user_buffer_used       (coe_user_buffer_used),
    .master_address             (master_address),
    .master_write               (master_write),
    .master_byteenable          (master_byteenable),
    .master_writedata           (master_writedata),
    .master_waitrequest         (master_waitrequest)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] mq[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  logic [31:0] base_m;
  logic [31:0] len_m;
  bit          fixed_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write the slave accepts on the coming edge.
  always @(negedge clk) begin
    if (!reset && master_write && !master_waitrequest) begin
      obs_addr.push_back(master_address);
      obs_data.push_back(master_writedata);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    coe_user_write_buffer = 1'b1;
    coe_user_buffer_data  = d;
    if (mq.size() < 32) mq.push_back(d);
    tick();
    coe_user_write_buffer = 1'b0;
  endtask

  task automatic start_go(input logic [31:0] b, input logic [31:0] l, input bit f);
    coe_control_write_base     = b;
    coe_control_write_length   = l;
    coe_control_fixed_location = f;
    coe_control_go             = 1'b1;
    master_waitrequest         = 1'b0;
    base_m  = b;
    len_m   = l & 32'hFFFF_FFFC;
    fixed_m = f;
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    tick();
    coe_control_go = 1'b0;
  endtask

  task automatic run_until_done(input int wait_pct, output int done_cyc);
    bit seen = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (coe_control_done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end else begin
        @(posedge clk);
        #1;
        master_waitrequest = ($urandom_range(99) < wait_pct);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: done still %0b after 2000 cycles, want 1", coe_control_done);
    end
    @(posedge clk);
    #1;
    master_waitrequest = 1'b0;
  endtask

  task automatic check_transfer(input string name);
    int n = int'(len_m >> 2);
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    n_cmp++;
    if (obs_addr.size() != n) begin
      n_err++;
      $display("FAIL %s count: got %0d writes, want %0d", name, obs_addr.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      exp_a = fixed_m ? base_m : base_m + 32'(4 * i);
      exp_d = (mq.size() > 0) ? mq.pop_front() : 32'h0;
      if (i < obs_addr.size()) begin
        n_cmp += 2;
        if (obs_addr[i] !== exp_a) begin
          n_err++;
          $display("FAIL %s addr[%0d]: got %h, want %h", name, i, obs_addr[i], exp_a);
        end
        if (obs_data[i] !== exp_d) begin
          n_err++;
          $display("FAIL %s data[%0d]: got %h, want %h", name, i, obs_data[i], exp_d);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (coe_control_done !== 1'b1) begin n_err++; $display("FAIL reset_done: got %b, want 1", coe_control_done); end
    if (master_write !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b, want 0", master_write); end
    if (coe_user_buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b, want 0", coe_user_buffer_full); end
    if (coe_user_buffer_used !== 6'd0) begin n_err++; $display("FAIL reset_used: got %0d, want 0", coe_user_buffer_used); end
    if (master_address !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h, want 0", master_address); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int dc;
    for (int i = 0; i < 4; i++) push_word($urandom);
    start_go(32'h1000, 32'd16, 1'b0);
    run_until_done(0, dc);
    n_cmp++;
    if (obs_cyc.size() != 4 || dc != obs_cyc[obs_cyc.size()-1] + 1) begin
      n_err++;
      $display("FAIL basic_done_timing: done at cycle %0d, want one cycle after last accept", dc);
    end
    check_transfer("basic");
  endtask

  task automatic test_waitrequest();
    int dc;
    logic [31:0] d[4];
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      push_word(d[i]);
    end
    start_go(32'h3000, 32'd16, 1'b0);
    tick();
    master_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp += 6;
      if (master_address !== 32'h3004) begin n_err++; $display("FAIL stall_addr: got %h, want 00003004", master_address); end
      if (master_writedata !== d[1]) begin n_err++; $display("FAIL stall_data: got %h, want %h", master_writedata, d[1]); end
      if (coe_user_buffer_used !== 6'd3) begin n_err++; $display("FAIL stall_used: got %0d, want 3", coe_user_buffer_used); end
      if (master_write !== 1'b1) begin n_err++; $display("FAIL stall_write: got %b, want 1", master_write); end
      if (coe_control_done !== 1'b0) begin n_err++; $display("FAIL stall_done: got %b, want 0", coe_control_done); end
      if (master_byteenable !== 4'hF) begin n_err++; $display("FAIL byteenable: got %h, want f", master_byteenable); end
      tick();
    end
    master_waitrequest = 1'b0;
    run_until_done(0, dc);
    check_transfer("waitreq");
  endtask

  task automatic test_fixed();
    int dc;
    logic [31:0] lens[2] = '{32'd12, 32'd14};
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 3; i++) push_word($urandom);
      start_go(32'h2000, lens[t], 1'b1);
      run_until_done(30, dc);
      check_transfer(t == 0 ? "fixed12" : "fixed14");
    end
  endtask

  task automatic test_full();
    int dc;
    for (int i = 0; i < 33; i++) push_word(32'hF000_0000 + 32'(i + 1));
    @(negedge clk);
    n_cmp += 2;
    if (coe_user_buffer_full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b, want 1", coe_user_buffer_full); end
    if (coe_user_buffer_used !== 6'd32) begin n_err++; $display("FAIL full_used: got %0d, want 32", coe_user_buffer_used); end
    tick();
    start_go(32'h4000, 32'd128, 1'b0);
    run_until_done(25, dc);
    check_transfer("full_drain");
    @(negedge clk);
    n_cmp += 2;
    if (coe_user_buffer_used !== 6'd0) begin n_err++; $display("FAIL drain_used: got %0d, want 0", coe_user_buffer_used); end
    if (coe_user_buffer_full !== 1'b0) begin n_err++; $display("FAIL drain_full: got %b, want 0", coe_user_buffer_full); end
    tick();
  endtask

  task automatic test_starve();
    int dc;
    start_go(32'h5000, 32'd8, 1'b0);
    push_word($urandom);
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp += 2;
      if (master_write !== 1'b0) begin n_err++; $display("FAIL starve_write: got %b, want 0", master_write); end
      if (coe_control_done !== 1'b0) begin n_err++; $display("FAIL starve_done: got %b, want 0", coe_control_done); end
      tick();
    end
    push_word($urandom);
    @(negedge clk);
    n_cmp++;
    if (master_write !== 1'b1) begin n_err++; $display("FAIL resume_write: got %b, want 1", master_write); end
    tick();
    run_until_done(0, dc);
    check_transfer("starve");
  endtask

  task automatic test_go_mid();
    int dc;
    logic [31:0] exp_a[5] = '{32'h7000, 32'h7004, 32'h7008, 32'h8000, 32'h8004};
    logic [31:0] exp_d;
    for (int i = 0; i < 6; i++) push_word($urandom);
    start_go(32'h7000, 32'd24, 1'b0);
    repeat (2) tick();
    coe_control_write_base   = 32'h8000;
    coe_control_write_length = 32'd8;
    coe_control_go           = 1'b1;
    tick();
    coe_control_go = 1'b0;
    run_until_done(0, dc);
    n_cmp++;
    if (obs_addr.size() != 5) begin n_err++; $display("FAIL gomid_count: got %0d writes, want 5", obs_addr.size()); end
    for (int i = 0; i < 5; i++) begin
      exp_d = (mq.size() > 0) ? mq.pop_front() : 32'h0;
      if (i < obs_addr.size()) begin
        n_cmp += 2;
        if (obs_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL gomid_addr[%0d]: got %h, want %h", i, obs_addr[i], exp_a[i]); end
        if (obs_data[i] !== exp_d) begin n_err++; $display("FAIL gomid_data[%0d]: got %h, want %h", i, obs_data[i], exp_d); end
      end
    end
    start_go(32'h9000, 32'd4, 1'b0);
    run_until_done(0, dc);
    check_transfer("gomid_tail");
  endtask

  task automatic test_reset_mid();
    int dc;
    for (int i = 0; i < 5; i++) push_word($urandom);
    start_go(32'h6000, 32'd20, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    @(negedge clk);
    n_cmp += 4;
    if (coe_user_buffer_used !== 6'd0) begin n_err++; $display("FAIL rstmid_used: got %0d, want 0", coe_user_buffer_used); end
    if (coe_control_done !== 1'b1) begin n_err++; $display("FAIL rstmid_done: got %b, want 1", coe_control_done); end
    if (master_write !== 1'b0) begin n_err++; $display("FAIL rstmid_write: got %b, want 0", master_write); end
    if (master_address !== 32'h0) begin n_err++; $display("FAIL rstmid_addr: got %h, want 0", master_address); end
    reset = 1'b0;
    mq.delete();
    tick();
    for (int i = 0; i < 2; i++) push_word($urandom);
    start_go(32'h6100, 32'd8, 1'b0);
    run_until_done(0, dc);
    check_transfer("after_reset");
  endtask

  task automatic test_random();
    int dc;
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) push_word($urandom);
      start_go($urandom & 32'hFFFF_FFFC, 32'(n * 4) + 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      run_until_done($urandom_range(0, 60), dc);
      check_transfer("random");
    end
  endtask

  initial begin
    reset                      = 1'b1;
    coe_control_fixed_location = 1'b0;
    coe_control_write_base     = 32'h0;
    coe_control_write_length   = 32'h0;
    coe_control_go             = 1'b0;
    coe_user_write_buffer      = 1'b0;
    coe_user_buffer_data       = 32'h0;
    master_waitrequest         = 1'b0;
    test_reset();
    test_basic();
    test_waitrequest();
    test_fixed();
    test_full();
    test_starve();
    test_go_mid();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
